// File: rtl/pb_pkg.sv
// pb_pkg: shared types and default constants for the push-button scan
// controller and its timing helpers.
//   pb_state_e  : scan FSM state (idle, waiting for a tick / scanning buttons)
//   PB_CLK_DIV  : system clocks per 1 ms sample tick at 50 MHz
//   PB_HIST     : debounce history length in samples
//   PB_HOLD_MS  : debounced-high ticks before a long-press pulse
package pb_pkg;

  typedef enum logic {
    PB_IDLE = 1'b0,
    PB_SCAN = 1'b1
  } pb_state_e;

  localparam int PB_CLK_DIV = 50000;
  localparam int PB_HIST    = 8;
  localparam int PB_HOLD_MS = 500;

endpackage

// File: rtl/pb_tick_gen.sv
// pb_tick_gen: free-running prescaler producing a one-cycle sample tick.
// The counter runs 0..CLK_DIV-1 and wraps; tick is high for the cycle in
// which the count sits at CLK_DIV-1.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   tick  : one-cycle pulse every CLK_DIV clocks
module pb_tick_gen
  import pb_pkg::*;
#(
  parameter int CLK_DIV = PB_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (cnt == CNT_MAX) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/pb_scan_ctrl.sv
// pb_scan_ctrl: multi-button debounce controller. One shared history
// update is time-multiplexed across N_BTN buttons: each sample tick starts
// a scan that services button 0, 1, ... N_BTN-1 on consecutive clocks.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   btn_in      : raw button inputs, asynchronous to clk
//   btn_level   : debounced level per button
//   btn_press   : one-cycle pulse on debounced 0->1
//   btn_release : one-cycle pulse on debounced 1->0
//   btn_hold    : one-cycle pulse after HOLD_MS debounced-high ticks
//   tick        : one-cycle sample tick, exported for downstream timing
module pb_scan_ctrl
  import pb_pkg::*;
#(
  parameter int N_BTN   = 4,
  parameter int CLK_DIV = PB_CLK_DIV,
  parameter int HIST    = PB_HIST,
  parameter int HOLD_MS = PB_HOLD_MS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_hold,
  output logic             tick
);

  localparam int            IW       = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int            HW       = $clog2(HOLD_MS + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_BTN - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_MS);

  // 2-flop synchroniser per button
  logic [N_BTN-1:0] sync_meta, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= btn_in;
      sync_q    <= sync_meta;
    end
  end

  pb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // ---------------- scan FSM ----------------
  pb_state_e     state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic          svc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PB_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      PB_IDLE: if (tick) begin
        state_nx = PB_SCAN;
        idx_nx   = '0;
      end
      PB_SCAN: if (idx == IDX_LAST) begin
        state_nx = PB_IDLE;
        idx_nx   = '0;
      end else begin
        idx_nx = idx + 1'b1;
      end
      default: begin
        state_nx = PB_IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  always_comb begin
    svc = 1'b0;
    if (state == PB_SCAN) svc = 1'b1;
  end

  // CLK_DIV > N_BTN+2 keeps every tick inside IDLE; a tick here would be lost.
  a_no_tick_in_scan: assert property (@(posedge clk) disable iff (!rst_n)
    !(state == PB_SCAN && tick));

  // ---------------- shared service datapath ----------------
  logic [N_BTN-1:0][HIST-1:0] hist;
  logic [N_BTN-1:0][HW-1:0]   hold_cnt;
  logic [HIST-1:0]            new_h;
  logic                       cur_lvl, new_lvl;
  logic [HW-1:0]              cur_cnt;

  // Level only moves on a unanimous history; mixed patterns hold it.
  always_comb begin
    new_h   = {hist[idx][HIST-2:0], sync_q[idx]};
    cur_lvl = btn_level[idx];
    cur_cnt = hold_cnt[idx];
    new_lvl = cur_lvl;
    if (&new_h)       new_lvl = 1'b1;
    else if (~|new_h) new_lvl = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist        <= '0;
      hold_cnt    <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_hold    <= '0;
    end else begin
      // Pulses default low so only the serviced bit can be high.
      btn_press   <= '0;
      btn_release <= '0;
      btn_hold    <= '0;
      if (svc) begin
        hist[idx]        <= new_h;
        btn_level[idx]   <= new_lvl;
        btn_press[idx]   <= new_lvl & ~cur_lvl;
        btn_release[idx] <= ~new_lvl & cur_lvl;
        // Counter saturates at HOLD_MAX, so the hold pulse fires once
        // per high period and re-arms only through a clear on release.
        if (!new_lvl) begin
          hold_cnt[idx] <= '0;
        end else if (cur_cnt != HOLD_MAX) begin
          hold_cnt[idx] <= cur_cnt + 1'b1;
          btn_hold[idx] <= (cur_cnt == HOLD_MAX - 1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pb_scan_ctrl.sv
module tb_pb_scan_ctrl;
  localparam int N   = 4;
  localparam int DIV = 10;
  localparam int H   = 8;
  localparam int HM  = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_hold;
  logic         tick;

  always #5 clk = ~clk;

  pb_scan_ctrl #(.N_BTN(N), .CLK_DIV(DIV), .HIST(H), .HOLD_MS(HM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_hold    (btn_hold),
    .tick        (tick)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: run lengths of identical samples per button, and the
  // number of ticks spent debounced-high in the current high period.
  int           run1 [N];
  int           run0 [N];
  int           hi   [N];
  logic [N-1:0] m_lvl;

  int cnt_press, cnt_rel, cnt_hold;
  logic [N-1:0] last_press [1:6];

  typedef struct {
    string        name;
    logic [N-1:0] btn;
    logic [N-1:0] tog;     // bits inverted on odd ticks of the phase
    int           ticks;
    int           e_press;
    int           e_rel;
    int           e_hold;
    logic [N-1:0] e_lvl;
  } phase_t;

  phase_t ph [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      run1[i] = 0; run0[i] = 0; hi[i] = 0;
    end
    m_lvl = '0;
  endtask

  // Drive b, wait for the next tick, then check the six cycles that follow
  // it (service window t+1..t+4 plus a margin) cycle by cycle.
  task automatic run_tick(input logic [N-1:0] b, input bit chk_period);
    logic [N-1:0] old_l, ev_p, ev_r, ev_h, ep, er, eh, el;
    int w;
    btn_in = b;
    w = 0;
    while (tick !== 1'b1 && w < 3*DIV) begin
      @(negedge clk);
      w++;
    end
    if (tick !== 1'b1) begin
      chk("tick_timeout", {31'd0, tick}, 32'd1);
      return;
    end
    if (chk_period) chk("tick_period", w, DIV - 6);

    old_l = m_lvl;
    ev_p = '0; ev_r = '0; ev_h = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) begin run1[i]++; run0[i] = 0; end
      else      begin run0[i]++; run1[i] = 0; end
      if (!m_lvl[i] && run1[i] >= H) begin m_lvl[i] = 1'b1; ev_p[i] = 1'b1; end
      if ( m_lvl[i] && run0[i] >= H) begin m_lvl[i] = 1'b0; ev_r[i] = 1'b1; end
      if (m_lvl[i]) begin
        if (hi[i] < HM) begin
          hi[i]++;
          if (hi[i] == HM) ev_h[i] = 1'b1;
        end
      end else begin
        hi[i] = 0;
      end
    end

    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        el[i] = (k >= 2 + i) ? m_lvl[i] : old_l[i];
        ep[i] = (k == 2 + i) && ev_p[i];
        er[i] = (k == 2 + i) && ev_r[i];
        eh[i] = (k == 2 + i) && ev_h[i];
      end
      chk("level",   btn_level,   el);
      chk("press",   btn_press,   ep);
      chk("release", btn_release, er);
      chk("hold",    btn_hold,    eh);
      chk("tick_low", {31'd0, tick}, 32'd0);
      last_press[k] = btn_press;
      cnt_press += $countones(btn_press);
      cnt_rel   += $countones(btn_release);
      cnt_hold  += $countones(btn_hold);
    end
  endtask

  initial begin
    logic [N-1:0] cur;
    int w;

    //           name      btn      tog      tk  prs rel hld lvl
    ph[0] = '{"idle",    4'b0000, 4'b0000,  3, 0, 0, 0, 4'b0000};
    ph[1] = '{"press0",  4'b0001, 4'b0000,  8, 1, 0, 0, 4'b0001};
    ph[2] = '{"rel0",    4'b0000, 4'b0000, 10, 0, 1, 1, 4'b0000};
    ph[3] = '{"repress", 4'b0001, 4'b0000, 12, 1, 0, 1, 4'b0001};
    ph[4] = '{"bounce1", 4'b0011, 4'b0010, 20, 0, 0, 0, 4'b0001};
    ph[5] = '{"press1",  4'b0011, 4'b0000,  8, 1, 0, 0, 4'b0011};
    ph[6] = '{"hold2",   4'b0111, 4'b0000, 30, 1, 0, 2, 4'b0111};
    ph[7] = '{"relall",  4'b0000, 4'b0000, 10, 0, 3, 0, 4'b0000};
    ph[8] = '{"simul",   4'b1001, 4'b0000,  8, 2, 0, 0, 4'b1001};

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_level", btn_level, 4'b0000);
    chk("rst_press", btn_press | btn_release | btn_hold, 4'b0000);
    chk("rst_tick",  {31'd0, tick}, 32'd0);
    rst_n = 1'b1;

    for (int p = 0; p < 9; p++) begin
      cnt_press = 0; cnt_rel = 0; cnt_hold = 0;
      for (int j = 0; j < ph[p].ticks; j++)
        run_tick(ph[p].btn ^ ((j % 2 == 1) ? ph[p].tog : 4'b0000), !(p == 0 && j == 0));
      chk({ph[p].name, "_npress"}, cnt_press, ph[p].e_press);
      chk({ph[p].name, "_nrel"},   cnt_rel,   ph[p].e_rel);
      chk({ph[p].name, "_nhold"},  cnt_hold,  ph[p].e_hold);
      chk({ph[p].name, "_lvl"},    btn_level, ph[p].e_lvl);
    end

    // Simultaneous rise of buttons 0 and 3: pulses at t+2 and t+5.
    chk("simul_p0",  last_press[2], 4'b0001);
    chk("simul_p3",  last_press[5], 4'b1000);
    chk("simul_gap", last_press[3] | last_press[4], 4'b0000);

    // Randomised runs: occasional single-bit flips so some runs stabilise.
    cur = 4'b1001;
    for (int j = 0; j < 80; j++) begin
      if ($urandom_range(0, 3) == 0) cur[$urandom_range(0, N-1)] ^= 1'b1;
      run_tick(cur, 1'b1);
    end

    // Reset in the middle of a scan with all levels high.
    for (int j = 0; j < H; j++) run_tick(4'b1111, 1'b1);
    chk("pre_rst_lvl", btn_level, 4'b1111);
    w = 0;
    while (tick !== 1'b1 && w < 3*DIV) begin @(negedge clk); w++; end
    chk("pre_rst_tick", {31'd0, tick}, 32'd1);
    @(negedge clk);
    @(negedge clk);          // FSM now servicing button 1
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_level", btn_level, 4'b0000);
    chk("midrst_pulse", btn_press | btn_release | btn_hold, 4'b0000);
    chk("midrst_tick",  {31'd0, tick}, 32'd0);
    btn_in = '0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("inrst_out", {btn_level, btn_press, btn_release, btn_hold}, 16'h0);
    end
    rst_n = 1'b1;
    // Release at a negedge: the cycle after is count 0, the tick cycle is
    // the tenth one, observed on the ninth falling edge.
    w = 0;
    while (w < 3*DIV) begin
      @(negedge clk);
      w++;
      chk("postrst_quiet", {btn_level, btn_press, btn_release, btn_hold}, 16'h0);
      if (tick === 1'b1) break;
    end
    chk("postrst_first_tick", w, DIV - 1);
    for (int j = 0; j < 3; j++) run_tick(4'b0000, j != 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
